serial_adder: RTL



---
 rtl/serial_adder_if.sv | 26 ++
 rtl/serial_adder.sv | 114 +++++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/busy/done handshake and operand/result bus for serial_adder
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf, zero
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf, zero
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial add/sub, LSB digit first; SERIAL_ADDER_FLAGS_EN enables ovf/zero
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;

  // Operands shift right each cycle, so the current digit is always the low DIGIT bits.
  logic [DIGIT:0]   cy;
  logic [DIGIT-1:0] dsum;
  logic [WIDTH-1:0] work_next;

  assign cy[0] = carry;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign dsum[i]  = op_a[i] ^ op_b[i] ^ cy[i];
    assign cy[i+1]  = (op_a[i] & op_b[i]) | (cy[i] & (op_a[i] ^ op_b[i]));
  end

  // New digit enters at the MSB side; after N digits the first one has reached bit 0.
  assign work_next = WIDTH'({dsum, work} >> DIGIT);

`ifdef SERIAL_ADDER_FLAGS_EN
  logic ovf_q;
  logic zero_q;

  // Flags are registered together with sum on the final-digit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (state == RUN && cnt == LAST) begin
      ovf_q  <= cy[DIGIT-1] ^ cy[DIGIT];
      zero_q <= (work_next == '0);
    end
  end

  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
`else
  assign bus.ovf  = 1'b0;
  assign bus.zero = 1'b0;
`endif

  // Control FSM and datapath: accept in IDLE, one digit per cycle in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      work   <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_a   <= bus.a;
            op_b   <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub ? 1'b1 : bus.cin;
            work   <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          op_a  <= op_a >> DIGIT;
          op_b  <= op_b >> DIGIT;
          work  <= work_next;
          carry <= cy[DIGIT];
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum_q  <= work_next;
            cout_q <= cy[DIGIT];
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule
